// File: rtl/load_unit.sv
//============================================================================
// Module   : load_unit
// Brief    : Single-outstanding load unit. Takes a load from execute, checks
//            alignment, fetches the enclosing dword from memory, extracts and
//            extends the addressed bytes, then holds the result for
//            writeback. Misaligned loads and bus errors return wb_err=1.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module load_unit #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    // request from execute
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    // memory read channel
    output logic              mem_arvalid,
    input  logic              mem_arready,
    output logic [ADDR_W-1:0] mem_araddr,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    // writeback
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [4:0]          rd_q, rd_d;
    logic                kill_q, kill_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                wb_err_q, wb_err_d;

    logic                misaligned;
    logic [DATA_W-1:0]   rdata_shifted;
    logic [DATA_W-1:0]   load_ext;

    // Alignment check on the incoming request (byte loads are always aligned)
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    // Move the addressed byte lane down to bit 0, then extend per size/sign
    assign rdata_shifted = mem_rdata >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_ext = '0;
        case (size_q)
            2'd0:    load_ext = {{56{signed_q & rdata_shifted[7]}},  rdata_shifted[7:0]};
            2'd1:    load_ext = {{48{signed_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            2'd2:    load_ext = {{32{signed_q & rdata_shifted[31]}}, rdata_shifted[31:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    // Next-state, captured request fields and handshake outputs
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        signed_d    = signed_q;
        rd_d        = rd_q;
        kill_d      = kill_q;
        wb_data_d   = wb_data_q;
        wb_err_d    = wb_err_q;
        req_ready   = 1'b0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        wb_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = ~flush;
                kill_d    = 1'b0;
                if (req_valid && !flush) begin
                    addr_d    = req_addr;
                    size_d    = req_size;
                    signed_d  = req_signed;
                    rd_d      = req_rd;
                    wb_data_d = '0;
                    wb_err_d  = misaligned;
                    // misaligned loads never touch memory
                    state_d   = misaligned ? RESP : ADDR;
                end
            end
            ADDR: begin
                // arvalid is never withdrawn once raised, even when flushed
                mem_arvalid = 1'b1;
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (mem_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                mem_rready = 1'b1;
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (mem_rvalid) begin
                    if (kill_q || flush) begin
                        // killed load: consume the beat and drop it
                        state_d = IDLE;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = RESP;
                        if (mem_rresp != 2'd0) begin
                            wb_err_d  = 1'b1;
                            wb_data_d = '0;
                        end else begin
                            wb_err_d  = 1'b0;
                            wb_data_d = load_ext;
                        end
                    end
                end
            end
            RESP: begin
                wb_valid = 1'b1;
                // a flush alongside wb_ready still counts as consumed
                if (wb_ready || flush) begin
                    state_d = IDLE;
                    kill_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= 2'd0;
            signed_q  <= 1'b0;
            rd_q      <= 5'd0;
            kill_q    <= 1'b0;
            wb_data_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            signed_q  <= signed_d;
            rd_q      <= rd_d;
            kill_q    <= kill_d;
            wb_data_q <= wb_data_d;
            wb_err_q  <= wb_err_d;
        end
    end

    assign mem_araddr = {addr_q[ADDR_W-1:3], 3'b000};
    assign wb_rd      = rd_q;
    assign wb_data    = wb_data_q;
    assign wb_err     = wb_err_q;

endmodule

`default_nettype wire

// File: tb/tb_load_unit.sv
//============================================================================
// Module   : tb_load_unit
// Brief    : Self-checking bench for load_unit. A transaction-level model
//            tracks the single outstanding load and predicts every output
//            each cycle; directed scenarios pin the model with literals,
//            then a randomized phase exercises flush/reset/backpressure.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_signed, flush;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic [4:0]  req_rd;
    logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
    logic [63:0] mem_araddr, mem_rdata;
    logic [1:0]  mem_rresp;
    logic        wb_valid, wb_ready, wb_err;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    int checks = 0;
    int errors = 0;

    load_unit #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_rd     (req_rd),
        .flush      (flush),
        .mem_arvalid(mem_arvalid),
        .mem_arready(mem_arready),
        .mem_araddr (mem_araddr),
        .mem_rvalid (mem_rvalid),
        .mem_rready (mem_rready),
        .mem_rdata  (mem_rdata),
        .mem_rresp  (mem_rresp),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_err     (wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: gather nb bytes little-endian from byte offset, then extend
    function automatic logic [63:0] load_val(input logic [63:0] d, input int off,
                                             input int nb, input bit sgn);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v[i*8 +: 8] = d[(off+i)*8 +: 8];
        if (sgn && v[nb*8-1]) for (int i = nb*8; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Transaction model of the one outstanding load
    bit          m_busy, m_mis, m_ar_done, m_have, m_kill, m_err, m_sgn;
    logic [63:0] m_addr, m_res;
    logic [4:0]  m_rd;
    int          m_nb;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_have = 0; m_kill = 0; m_ar_done = 0; m_mis = 0;
        end else if (!m_busy) begin
            if (req_valid && !flush) begin
                m_busy = 1; m_addr = req_addr; m_nb = 1 << req_size;
                m_sgn = req_signed; m_rd = req_rd; m_kill = 0; m_ar_done = 0;
                m_mis = (int'(req_addr[2:0]) % m_nb) != 0;
                m_have = m_mis; m_res = '0; m_err = m_mis;
            end
        end else if (m_have) begin
            if (wb_ready || flush) begin m_busy = 0; m_have = 0; end
        end else if (!m_ar_done) begin
            if (flush) m_kill = 1;
            if (mem_arready) m_ar_done = 1;
        end else begin
            if (flush) m_kill = 1;
            if (mem_rvalid) begin
                if (m_kill) m_busy = 0;
                else begin
                    m_have = 1;
                    if (mem_rresp != 2'd0) begin m_res = '0; m_err = 1; end
                    else begin m_res = load_val(mem_rdata, int'(m_addr[2:0]), m_nb, m_sgn); m_err = 0; end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_arvalid", mem_arvalid, 0);
            chk("rst_rready", mem_rready, 0);
            chk("rst_wb_valid", wb_valid, 0);
            chk("rst_wb_err", wb_err, 0);
            chk("rst_wb_data", wb_data, 0);
            chk("rst_wb_rd", wb_rd, 0);
        end else begin
            chk("req_ready", req_ready, !m_busy && !flush);
            chk("arvalid", mem_arvalid, m_busy && !m_mis && !m_ar_done);
            chk("rready", mem_rready, m_busy && !m_mis && m_ar_done && !m_have);
            chk("wb_valid", wb_valid, m_busy && m_have);
            if (m_busy && !m_mis && !m_ar_done) chk("araddr", mem_araddr, {m_addr[63:3], 3'b000});
            if (m_busy && m_have) begin
                chk("wb_rd", wb_rd, m_rd);
                chk("wb_data", wb_data, m_res);
                chk("wb_err", wb_err, m_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_addr = '0; req_size = 0; req_signed = 0; req_rd = 0;
        flush = 0; mem_arready = 0; mem_rvalid = 0; mem_rdata = '0; mem_rresp = 0;
        wb_ready = 0;
    endtask

    task automatic issue(input logic [63:0] a, input logic [1:0] sz, input bit sg, input logic [4:0] rd);
        req_valid = 1; req_addr = a; req_size = sz; req_signed = sg; req_rd = rd;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        chk("post_rst_req_ready", req_ready, 1);

        // lb signed, zero wait: result at accept+3
        issue(64'h8000_0003, 2'd0, 1, 5'd3);
        mem_arready = 1; mem_rvalid = 1; mem_rdata = 64'h1122_3344_8566_7788;
        tick(); req_valid = 0;
        chk("lb_arvalid", mem_arvalid, 1);
        chk("lb_araddr", mem_araddr, 64'h8000_0000);
        tick();
        chk("lb_wb_early", wb_valid, 0);
        tick();
        chk("lb_wb_valid", wb_valid, 1);
        chk("lb_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF85);
        chk("lb_wb_rd", wb_rd, 5'd3);
        mem_arready = 0; mem_rvalid = 0; wb_ready = 1;
        tick(); wb_ready = 0;
        chk("lb_done", wb_valid, 0);

        // lhu with arready delayed 4 cycles
        issue(64'h8000_0006, 2'd1, 0, 5'd4);
        tick(); req_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("lhu_arvalid_hold", mem_arvalid, 1);
            chk("lhu_araddr_hold", mem_araddr, 64'h8000_0000);
            tick();
        end
        mem_arready = 1;
        tick(); mem_arready = 0;
        chk("lhu_rready", mem_rready, 1);
        mem_rvalid = 1; mem_rdata = 64'h1122_3344_8566_7788;
        tick(); mem_rvalid = 0;
        chk("lhu_wb_data", wb_data, 64'h0000_0000_0000_1122);
        chk("lhu_wb_err", wb_err, 0);
        wb_ready = 1; tick(); wb_ready = 0;

        // misaligned lw: no memory access, error next cycle
        issue(64'h8000_0002, 2'd2, 1, 5'd5);
        tick(); req_valid = 0;
        chk("mis_arvalid", mem_arvalid, 0);
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_wb_err", wb_err, 1);
        chk("mis_wb_data", wb_data, 0);
        wb_ready = 1; tick(); wb_ready = 0;

        // ld with bus error, writeback stalled 3 cycles
        issue(64'h8000_0008, 2'd3, 0, 5'd9);
        mem_arready = 1; mem_rvalid = 1; mem_rresp = 2'd2; mem_rdata = 64'hCAFE_F00D_1234_5678;
        tick(); req_valid = 0;
        tick(); tick();
        mem_arready = 0; mem_rvalid = 0; mem_rresp = 0;
        for (int i = 0; i < 3; i++) begin
            chk("berr_wb_valid", wb_valid, 1);
            chk("berr_wb_err", wb_err, 1);
            chk("berr_wb_data", wb_data, 0);
            chk("berr_wb_rd", wb_rd, 5'd9);
            tick();
        end
        wb_ready = 1; tick(); wb_ready = 0;
        chk("berr_done", wb_valid, 0);

        // flush while address is pending
        issue(64'h0000_0100, 2'd2, 0, 5'd6);
        tick(); req_valid = 0;
        tick();
        flush = 1; tick(); flush = 0;
        chk("fl_arvalid_kept", mem_arvalid, 1);
        chk("fl_req_ready_busy", req_ready, 0);
        mem_arready = 1; tick(); mem_arready = 0;
        chk("fl_rready", mem_rready, 1);
        mem_rvalid = 1; mem_rdata = 64'h0123_4567_89AB_CDEF;
        tick(); mem_rvalid = 0;
        chk("fl_no_wb", wb_valid, 0);
        chk("fl_req_ready", req_ready, 1);
        tick();
        chk("fl_no_wb_later", wb_valid, 0);

        // asynchronous reset in DATA, then stale rvalid, then lwu
        issue(64'h0000_0010, 2'd2, 0, 5'd7);
        mem_arready = 1;
        tick(); req_valid = 0;
        tick(); mem_arready = 0;
        chk("ar_rready_before", mem_rready, 1);
        #1 rst_n = 0;
        #1;
        chk("ar_async_rready", mem_rready, 0);
        chk("ar_async_arvalid", mem_arvalid, 0);
        chk("ar_async_wb_valid", wb_valid, 0);
        chk("ar_async_wb_rd", wb_rd, 0);
        chk("ar_async_wb_data", wb_data, 0);
        chk("ar_async_wb_err", wb_err, 0);
        tick(); tick();
        rst_n = 1; mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(); mem_rvalid = 0;
        chk("stale_no_wb", wb_valid, 0);
        chk("stale_req_ready", req_ready, 1);
        issue(64'h0000_0010, 2'd2, 0, 5'd7);
        mem_arready = 1; mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF_0000_0000;
        tick(); req_valid = 0;
        tick(); tick();
        mem_arready = 0; mem_rvalid = 0;
        chk("lwu_wb_valid", wb_valid, 1);
        chk("lwu_wb_data", wb_data, 0);
        chk("lwu_wb_err", wb_err, 0);
        wb_ready = 1; tick(); wb_ready = 0;

        // randomized traffic with flush, backpressure, errors and resets
        for (int n = 0; n < 4000; n++) begin
            req_valid   = 1'($urandom % 2);
            req_addr    = {$urandom, $urandom};
            if ($urandom % 2 == 0) req_addr[2:0] = 3'd0;
            req_size    = 2'($urandom % 4);
            req_signed  = 1'($urandom % 2);
            req_rd      = 5'($urandom % 32);
            flush       = ($urandom % 20 == 0);
            mem_arready = 1'($urandom % 2);
            mem_rvalid  = 1'($urandom % 2);
            mem_rdata   = {$urandom, $urandom};
            mem_rresp   = ($urandom % 8 == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            wb_ready    = 1'($urandom % 2);
            rst_n       = ($urandom % 400 != 0);
            tick();
        end

        idle_inputs();
        rst_n = 1;
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 Parameter ADDR_W, 64, byte-address width of request and memory address.
REQ-002 Parameter DATA_W, 64, memory data-bus width; fixed at 64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  1  load request from execute stage.
REQ-006 req_ready  output  1  load unit can accept a request.
REQ-007 req_addr  input  ADDR_W  byte address of the load.
REQ-008 req_size  input  2  access size: 0 byte, 1 half, 2 word, 3 dword.
REQ-009 req_signed  input  1  1 = sign-extend, 0 = zero-extend.
REQ-010 req_rd  input  5  destination register index.
REQ-011 flush  input  1  kill any in-flight load.
REQ-012 mem_arvalid  output  1  read-address valid.
REQ-013 mem_arready  input  1  memory accepts the read address.
REQ-014 mem_araddr  output  ADDR_W  dword-aligned read address.
REQ-015 mem_rvalid  input  1  read data valid.
REQ-016 mem_rready  output  1  load unit accepts read data.
REQ-017 mem_rdata  input  64  read data, little-endian.
REQ-018 mem_rresp  input  2  read response; nonzero = bus error.
REQ-019 wb_valid  output  1  result available for writeback.
REQ-020 wb_ready  input  1  writeback consumes the result.
REQ-021 wb_rd  output  5  destination register of the result.
REQ-022 wb_data  output  64  extended load result.
REQ-023 wb_err  output  1  misaligned or bus-error load.

Function
REQ-024 FSM states SHALL be IDLE, ADDR, DATA, RESP; one load in flight at most.
REQ-025 req_ready SHALL equal (state==IDLE) and not flush.
REQ-026 Accept on req_valid and req_ready; addr, size, signed, rd captured into registers that hold until return to IDLE.
REQ-027 Misalignment: half with addr[0]=1, word with addr[1:0]!=0, dword with addr[2:0]!=0; a misaligned accept SHALL go IDLE->RESP with wb_err=1, wb_data=0, and no memory access.
REQ-028 Aligned accept SHALL go IDLE->ADDR; in ADDR, mem_arvalid=1 and mem_araddr={addr[ADDR_W-1:3],3'b000}, both held stable until mem_arready.
REQ-029 ADDR->DATA on mem_arready; first possible mem_arvalid cycle is the cycle after acceptance.
REQ-030 In DATA, mem_rready=1; on mem_rvalid, select bytes starting at byte lane addr[2:0], extend per size/signed to 64 bits, latch into wb_data, go RESP.
REQ-031 Nonzero mem_rresp SHALL latch wb_err=1, wb_data=0.
REQ-032 In RESP, wb_valid=1 with wb_rd/wb_data/wb_err stable until wb_ready; RESP->IDLE on wb_ready.
REQ-033 Minimum latency with arready and rvalid asserted immediately: accept at cycle N, wb_valid at cycle N+3.
REQ-034 wb_valid, mem_arvalid and mem_rready SHALL be 0 outside their states.
REQ-035 flush in IDLE: no acceptance that cycle.
REQ-036 flush in ADDR or DATA: set kill flag; handshake completes normally (arvalid not withdrawn), and returned data is discarded; then go to IDLE with no wb_valid.
REQ-037 flush in RESP: drop wb_valid next cycle, go IDLE; a flush in the same cycle as wb_ready still counts as consumed.
REQ-038 kill flag SHALL clear on entering IDLE.

Reset
REQ-039 rst_n low SHALL immediately force state IDLE and kill=0.
REQ-040 During reset: mem_arvalid=0, mem_rready=0, wb_valid=0, wb_err=0, wb_data=0, wb_rd=0; req_ready=1 after deassertion.
REQ-041 Reset mid-transaction abandons it; stale mem_rvalid after reset in IDLE SHALL be ignored.

Verification
REQ-042 lb signed addr 0x8000_0003, rdata 0x1122_3344_8566_7788, zero-wait -> araddr 0x8000_0000, wb_data 0xFFFF_FFFF_FFFF_FF85 at accept+3.
REQ-043 lhu addr 0x8000_0006, same rdata, arready delayed 4 cycles -> araddr stable all 4 cycles, wb_data 0x1122.
REQ-044 lw addr 0x8000_0002 -> no mem_arvalid, wb_valid next cycle, wb_err=1, wb_data=0.
REQ-045 ld addr 0x8000_0008, mem_rresp=2 -> wb_err=1, wb_data=0; wb_ready held low 3 cycles -> outputs stable.
REQ-046 flush one cycle after arvalid (arready low) -> arvalid stays until arready, data consumed, no wb_valid, req_ready back high.
REQ-047 rst_n pulsed low in DATA -> all outputs reset asynchronously; following lwu addr 0x10, rdata 0xDEAD_BEEF_0000_0000 returns 0 correctly.
